// File: rtl/rc4_search_pkg.sv
// Shared types and defaults for the RC4 keyspace search scheduler.
package rc4_search_pkg;

  localparam int KEY_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FOUND,
    EXHAUSTED
  } sched_state_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_BUSY,
    SLOT_RETIRED
  } slot_state_t;

endpackage

// File: rtl/rc4_key_search_sched_key_slot.sv
// One core's slot: tracks whether the core is idle, busy or retired.
// Holds the next key this core will be given.
// Holds the key currently being decrypted.
module key_slot
  import rc4_search_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEFAULT,
  parameter int STRIDE = 4,
  parameter int IDX    = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_i,
  input  logic             run_i,
  input  logic [KEY_W-1:0] keyLo_i,
  input  logic [KEY_W-1:0] keyHi_i,
  input  logic             done_i,
  output logic             start_o,
  output logic             busy_o,
  output logic             retireNext_o,
  output logic [KEY_W-1:0] key_o
);

  // One extra bit so that stepping past an all-ones key_hi cannot wrap to zero.
  localparam logic [KEY_W:0] STRIDE_W = (KEY_W+1)'(STRIDE);
  localparam logic [KEY_W:0] OFFSET_W = (KEY_W+1)'(IDX);

  slot_state_t      state_q, state_d;
  logic [KEY_W:0]   nextKey_q, nextKey_d;
  logic [KEY_W-1:0] curKey_q, curKey_d;
  logic [KEY_W:0]   hiExt;

  assign hiExt = {1'b0, keyHi_i};

  // Slot transitions: seed on init, then issue/retire/free while the search runs.
  always_comb begin
    state_d   = state_q;
    nextKey_d = nextKey_q;
    curKey_d  = curKey_q;
    start_o   = 1'b0;
    if (init_i) begin
      state_d   = SLOT_IDLE;
      nextKey_d = {1'b0, keyLo_i} + OFFSET_W;
    end else if (run_i) begin
      case (state_q)
        SLOT_IDLE: begin
          if (nextKey_q <= hiExt) begin
            start_o   = 1'b1;
            curKey_d  = nextKey_q[KEY_W-1:0];
            nextKey_d = nextKey_q + STRIDE_W;
            state_d   = SLOT_BUSY;
          end else begin
            state_d = SLOT_RETIRED;
          end
        end
        SLOT_BUSY: begin
          if (done_i) begin
            state_d = SLOT_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // The key is presented combinationally in the issue cycle and held afterwards.
  always_comb begin
    key_o        = start_o ? nextKey_q[KEY_W-1:0] : curKey_q;
    busy_o       = (state_q == SLOT_BUSY);
    retireNext_o = (state_d == SLOT_RETIRED);
  end

  // Slot state and key registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SLOT_RETIRED;
      nextKey_q <= '0;
      curKey_q  <= '0;
    end else begin
      state_q   <= state_d;
      nextKey_q <= nextKey_d;
      curKey_q  <= curKey_d;
    end
  end

endmodule

// File: rtl/rc4_key_search_sched.sv
// Keyspace scheduler for the RC4 brute-force search.
// Deals keys from [key_lo, key_hi] to CORES decrypt cores with stride CORES.
// Reports the first valid key, exhaustion of the range, or returns idle on abort.
module rc4_key_search_sched
  import rc4_search_pkg::*;
#(
  parameter int CORES = 4,
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int CNT_W = 25,
  localparam int CID_W = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [KEY_W-1:0]       key_lo,
  input  logic [KEY_W-1:0]       key_hi,
  output logic [CORES-1:0]       core_start,
  output logic [CORES*KEY_W-1:0] core_key,
  input  logic [CORES-1:0]       core_done,
  input  logic [CORES-1:0]       core_valid,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic [KEY_W-1:0]       found_key,
  output logic [CID_W-1:0]       found_core,
  output logic [CNT_W-1:0]       keys_tried
);

  sched_state_t     state_q, state_d;
  logic [KEY_W-1:0] keyLo_q, keyLo_d;
  logic [KEY_W-1:0] keyHi_q, keyHi_d;
  logic             found_q, found_d;
  logic             exhausted_q, exhausted_d;
  logic [KEY_W-1:0] foundKey_q, foundKey_d;
  logic [CID_W-1:0] foundCore_q, foundCore_d;
  logic [CNT_W-1:0] keysTried_q, keysTried_d;

  logic             runAct;
  logic             initAct;
  logic             startAccept;
  logic [CORES-1:0] slotBusy;
  logic [CORES-1:0] retireNext;
  logic [KEY_W-1:0] slotKey [CORES];
  logic [CORES-1:0] accept;
  logic             allRetiredNext;
  logic             hit;
  logic [CID_W-1:0] hitCore;
  logic [KEY_W-1:0] hitKey;
  logic [CNT_W-1:0] acceptCount;

  assign runAct         = (state_q == RUN) && !abort;
  assign initAct        = (state_q == INIT);
  assign startAccept    = start && !abort && (state_q inside {IDLE, FOUND, EXHAUSTED});
  assign accept         = core_done & slotBusy & {CORES{runAct}};
  assign allRetiredNext = &retireNext;

  for (genvar g = 0; g < CORES; g++) begin : gSlot
    key_slot #(
      .KEY_W (KEY_W),
      .STRIDE(CORES),
      .IDX   (g)
    ) uSlot (
      .clk_i       (CLOCK_50),
      .rst_ni      (reset),
      .init_i      (initAct),
      .run_i       (runAct),
      .keyLo_i     (keyLo_q),
      .keyHi_i     (keyHi_q),
      .done_i      (core_done[g]),
      .start_o     (core_start[g]),
      .busy_o      (slotBusy[g]),
      .retireNext_o(retireNext[g]),
      .key_o       (slotKey[g])
    );
    assign core_key[g*KEY_W +: KEY_W] = slotKey[g];
  end

  // Lowest-index core reporting a valid message wins; also counts accepted completions.
  always_comb begin
    hit         = 1'b0;
    hitCore     = '0;
    hitKey      = '0;
    acceptCount = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      acceptCount = acceptCount + CNT_W'(accept[i]);
      if (accept[i] && core_valid[i]) begin
        hit     = 1'b1;
        hitCore = CID_W'(i);
        hitKey  = slotKey[i];
      end
    end
  end

  // Global search FSM; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (startAccept) state_d = INIT;
        INIT:      state_d = RUN;
        RUN: begin
          if (hit) begin
            state_d = FOUND;
          end else if (allRetiredNext) begin
            state_d = EXHAUSTED;
          end
        end
        FOUND:     if (startAccept) state_d = INIT;
        EXHAUSTED: if (startAccept) state_d = INIT;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Result registers: cleared when a search is accepted, updated while it runs.
  always_comb begin
    keyLo_d     = keyLo_q;
    keyHi_d     = keyHi_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    foundKey_d  = foundKey_q;
    foundCore_d = foundCore_q;
    keysTried_d = keysTried_q;
    if (startAccept) begin
      keyLo_d     = key_lo;
      keyHi_d     = key_hi;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      foundKey_d  = '0;
      foundCore_d = '0;
      keysTried_d = '0;
    end else if (runAct) begin
      keysTried_d = keysTried_q + acceptCount;
      if (hit) begin
        found_d     = 1'b1;
        foundKey_d  = hitKey;
        foundCore_d = hitCore;
      end else if (allRetiredNext) begin
        exhausted_d = 1'b1;
      end
    end
  end

  // Scheduler state and result registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      keyLo_q     <= '0;
      keyHi_q     <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      foundKey_q  <= '0;
      foundCore_q <= '0;
      keysTried_q <= '0;
    end else begin
      state_q     <= state_d;
      keyLo_q     <= keyLo_d;
      keyHi_q     <= keyHi_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      foundKey_q  <= foundKey_d;
      foundCore_q <= foundCore_d;
      keysTried_q <= keysTried_d;
    end
  end

  // Status outputs come straight from state and result registers.
  always_comb begin
    busy       = (state_q == INIT) || (state_q == RUN);
    found      = found_q;
    exhausted  = exhausted_q;
    found_key  = foundKey_q;
    found_core = foundCore_q;
    keys_tried = keysTried_q;
  end

endmodule

// File: tb/tb_rc4_key_search_sched.sv
// Self-checking bench for rc4_key_search_sched with four modelled decrypt cores.
module tb_rc4_key_search_sched;

  typedef struct {
    int core;
    int key;
  } issue_t;

  typedef struct {
    int f;
    int e;
    int key;
    int core;
    int tried;
  } result_t;

  logic        CLOCK_50;
  logic        reset;
  logic        start;
  logic        abort;
  logic [23:0] key_lo;
  logic [23:0] key_hi;
  logic [3:0]  core_start;
  logic [95:0] core_key;
  logic [3:0]  core_done;
  logic [3:0]  core_valid;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [23:0] found_key;
  logic [1:0]  found_core;
  logic [24:0] keys_tried;

  int compareCount  = 0;
  int mismatchCount = 0;

  issue_t  issueQ[$];
  result_t resultQ[$];

  int          lat[4];
  int          cnt[4];
  logic [23:0] heldKey[4];
  int          validA = -1;
  int          validB = -1;
  logic        prevFound = 1'b0;
  logic        prevExh = 1'b0;

  rc4_key_search_sched #(
    .CORES(4),
    .KEY_W(24),
    .CNT_W(25)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .key_lo    (key_lo),
    .key_hi    (key_hi),
    .core_start(core_start),
    .core_key  (core_key),
    .core_done (core_done),
    .core_valid(core_valid),
    .busy      (busy),
    .found     (found),
    .exhausted (exhausted),
    .found_key (found_key),
    .found_core(found_core),
    .keys_tried(keys_tried)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] lo, input logic [23:0] hi);
    @(negedge CLOCK_50);
    key_lo = lo;
    key_hi = hi;
    start  = 1'b1;
    @(negedge CLOCK_50);
    start  = 1'b0;
  endtask

  task automatic pushIssues(input int lo, input int last);
    for (int k = lo; k <= last; k++) begin
      issueQ.push_back('{core: (k - lo) % 4, key: k});
    end
  endtask

  task automatic pushResult(input int f, input int e, input int key, input int core, input int tried);
    resultQ.push_back('{f: f, e: e, key: key, core: core, tried: tried});
  endtask

  task automatic setLatency(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0;
    lat[1] = l1;
    lat[2] = l2;
    lat[3] = l3;
  endtask

  task automatic waitResult(input int budget);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while (!(found || exhausted) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!(found || exhausted)) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL waitResult: no found/exhausted within %0d cycles, got 0, want 1", budget);
    end
    repeat (3) @(negedge CLOCK_50);
  endtask

  // Behavioural cores: answer each core_start after lat[i] cycles, valid only for chosen keys.
  initial begin
    core_done  = '0;
    core_valid = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i]     = 0;
      heldKey[i] = '0;
      lat[i]     = 1;
    end
    forever begin
      @(negedge CLOCK_50);
      core_done  = '0;
      core_valid = '0;
      if (!reset) begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              core_done[i]  = 1'b1;
              core_valid[i] = (int'(heldKey[i]) == validA) || (int'(heldKey[i]) == validB);
            end
          end
          if (core_start[i]) begin
            heldKey[i] = core_key[i*24 +: 24];
            cnt[i]     = lat[i];
          end
        end
      end
    end
  end

  // Monitor: every core_start and every rising found/exhausted pops an expectation.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          if (core_start[i]) begin
            int idx;
            idx = -1;
            for (int j = 0; j < issueQ.size(); j++) begin
              if (issueQ[j].core == i) begin
                idx = j;
                break;
              end
            end
            if (idx < 0) begin
              compareCount++;
              mismatchCount++;
              $display("[TB] FAIL unexpectedIssue: core %0d got key 0x%0h, want no start", i, core_key[i*24 +: 24]);
            end else begin
              checkOutput("issueKey", 32'(core_key[i*24 +: 24]), 32'(issueQ[idx].key));
              issueQ.delete(idx);
            end
          end
        end
        if ((found && !prevFound) || (exhausted && !prevExh)) begin
          if (resultQ.size() == 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL unexpectedResult: found=%0d exhausted=%0d, want none", found, exhausted);
          end else begin
            result_t r;
            r = resultQ.pop_front();
            checkOutput("resFound", 32'(found), 32'(r.f));
            checkOutput("resExhausted", 32'(exhausted), 32'(r.e));
            checkOutput("resFoundKey", 32'(found_key), 32'(r.key));
            checkOutput("resFoundCore", 32'(found_core), 32'(r.core));
            checkOutput("resKeysTried", 32'(keys_tried), 32'(r.tried));
          end
        end
      end
      prevFound = found;
      prevExh   = exhausted;
    end
  end

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    key_lo = '0;
    key_hi = '0;
    #2;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstFound", 32'(found), 32'd0);
    checkOutput("rstExhausted", 32'(exhausted), 32'd0);
    checkOutput("rstCoreStart", 32'(core_start), 32'd0);
    checkOutput("rstKeysTried", 32'(keys_tried), 32'd0);
    checkOutput("rstCoreKeyLo", core_key[31:0], 32'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;

    // Range 0..15, only key 9 valid; batches of four finish together.
    setLatency(1, 1, 1, 1);
    validA = 9;
    validB = -1;
    pushIssues(0, 11);
    pushResult(1, 0, 9, 1, 12);
    applyStimulus(24'd0, 24'd15);
    waitResult(200);

    // Range 0..10 never valid; also checks first-issue latency.
    validA = -1;
    pushIssues(0, 10);
    pushResult(0, 1, 0, 0, 11);
    applyStimulus(24'd0, 24'd10);
    checkOutput("latInitStart", 32'(core_start), 32'd0);
    checkOutput("latInitBusy", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    checkOutput("latFirstStart", 32'(core_start), 32'hF);
    waitResult(200);

    // Range ending at all-ones must not wrap to zero.
    pushIssues(24'hFFFFFC, 24'hFFFFFF);
    pushResult(0, 1, 0, 0, 4);
    applyStimulus(24'hFFFFFC, 24'hFFFFFF);
    waitResult(200);

    // Cores 1 and 2 hit in the same cycle; core 3 finishes after FOUND.
    setLatency(1, 3, 3, 6);
    validA = 1;
    validB = 2;
    pushIssues(0, 3);
    pushResult(1, 0, 1, 1, 3);
    applyStimulus(24'd0, 24'd3);
    waitResult(200);
    repeat (8) @(negedge CLOCK_50);
    checkOutput("lateDoneTried", 32'(keys_tried), 32'd3);
    checkOutput("lateDoneCore", 32'(found_core), 32'd1);

    // Abort a long search shortly after it starts, then restart it.
    setLatency(3, 3, 3, 3);
    validA = -1;
    validB = -1;
    pushIssues(0, 3);
    applyStimulus(24'd0, 24'd1000);
    repeat (4) @(negedge CLOCK_50);
    abort = 1'b1;
    @(negedge CLOCK_50);
    abort = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortTried", 32'(keys_tried), 32'd0);
    checkOutput("abortFound", 32'(found), 32'd0);
    checkOutput("abortExhausted", 32'(exhausted), 32'd0);
    repeat (10) @(negedge CLOCK_50);
    checkOutput("abortIssuesLeft", 32'(issueQ.size()), 32'd0);
    validA = 500;
    pushIssues(0, 503);
    pushResult(1, 0, 500, 0, 504);
    applyStimulus(24'd0, 24'd1000);
    waitResult(3000);

    // Asynchronous reset in the middle of a run, then an empty range.
    setLatency(2, 2, 2, 2);
    validA = -1;
    pushIssues(0, 3);
    applyStimulus(24'd0, 24'd15);
    repeat (3) @(negedge CLOCK_50);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncBusy", 32'(busy), 32'd0);
    checkOutput("asyncFound", 32'(found), 32'd0);
    checkOutput("asyncExhausted", 32'(exhausted), 32'd0);
    checkOutput("asyncFoundKey", 32'(found_key), 32'd0);
    checkOutput("asyncFoundCore", 32'(found_core), 32'd0);
    checkOutput("asyncTried", 32'(keys_tried), 32'd0);
    checkOutput("asyncCoreStart", 32'(core_start), 32'd0);
    checkOutput("asyncCoreKeyHi", core_key[95:64], 32'd0);
    checkOutput("asyncCoreKeyLo", core_key[31:0], 32'd0);
    issueQ.delete();
    @(negedge CLOCK_50);
    reset = 1'b1;
    pushResult(0, 1, 0, 0, 0);
    applyStimulus(24'd5, 24'd2);
    checkOutput("emptyT1Exh", 32'(exhausted), 32'd0);
    checkOutput("emptyT1Busy", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    checkOutput("emptyT2Exh", 32'(exhausted), 32'd0);
    checkOutput("emptyT2Busy", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    checkOutput("emptyT3Exh", 32'(exhausted), 32'd1);
    checkOutput("emptyT3Busy", 32'(busy), 32'd0);
    checkOutput("emptyT3Tried", 32'(keys_tried), 32'd0);
    repeat (4) @(negedge CLOCK_50);

    checkOutput("issuesDrained", 32'(issueQ.size()), 32'd0);
    checkOutput("resultsDrained", 32'(resultQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
